// File: rtl/cdb_arbiter_pkg.sv
// Shared Tomasulo datapath definitions (tag/data encodings also used by the operand
// selectors and reservation stations) plus arbiter-local constants.
package cdb_arbiter_pkg;

    localparam int TAG_W  = 3;
    localparam int DATA_W = 16;

    localparam logic [TAG_W-1:0]  TAG_NONE  = 3'b000;
    localparam logic [DATA_W-1:0] DATA_NONE = 16'b1111_1111_1111_0000;

    localparam int N_UF_DEFAULT = 3;

    localparam int               CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Common Data Bus request/broadcast bundle: functional units drive requests (master),
// the arbiter drives grants and the registered broadcast (slave).
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int N_UF = N_UF_DEFAULT
);

    logic                     Flush;
    logic [N_UF-1:0]          Req;
    logic [N_UF*TAG_W-1:0]    Req_tag;
    logic [N_UF*DATA_W-1:0]   Req_data;
    logic [N_UF-1:0]          Ack;
    logic [TAG_W-1:0]         Qi_CDB;
    logic [DATA_W-1:0]        Qi_CDB_data;
    logic                     CDB_valid;

    modport master (
        output Flush, Req, Req_tag, Req_data,
        input  Ack, Qi_CDB, Qi_CDB_data, CDB_valid
    );

    modport slave (
        input  Flush, Req, Req_tag, Req_data,
        output Ack, Qi_CDB, Qi_CDB_data, CDB_valid
    );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of elig searching last+1, last+2, ...
// modulo N_UF.
module cdb_arbiter_rr_pick #(
    parameter int N_UF  = 3,
    parameter int PTR_W = $clog2(N_UF)
) (
    input  logic [N_UF-1:0]  elig,
    input  logic [PTR_W-1:0] last,
    output logic [N_UF-1:0]  grant,
    output logic [PTR_W-1:0] win,
    output logic             any
);

    int cand;

    // NOTE: every output gets a default before the loop so no path leaves a latch.
    always_comb begin
        grant = '0;
        win   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int k = 1; k <= N_UF; k++) begin
            cand = (int'(last) + k) % N_UF;
            if (!any && elig[cand]) begin
                any         = 1'b1;
                win         = PTR_W'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin grant of one functional unit per cycle, registered broadcast
// and one-cycle Ack. Optional statistics counters are built when CDB_STATS_EN is defined.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_UF = N_UF_DEFAULT
) (
    input  logic             Clock,
    input  logic             Reset,
`ifdef CDB_STATS_EN
    output logic [CNT_W-1:0] Bcast_count,
    output logic [CNT_W-1:0] Conflict_count,
`endif
    cdb_arbiter_if.slave     bus
);

    localparam int PTR_W = $clog2(N_UF);

    logic [N_UF-1:0]   elig;
    logic [N_UF-1:0]   grant;
    logic [PTR_W-1:0]  win;
    logic              any;

    logic [N_UF-1:0]   ack_q;
    logic [PTR_W-1:0]  last_q;
    logic [TAG_W-1:0]  tag_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    // A UF still seeing its Ack is masked so one result is never broadcast twice.
    for (genvar i = 0; i < N_UF; i++) begin : g_elig
        assign elig[i] = bus.Req[i] & ~ack_q[i] &
                         (bus.Req_tag[i*TAG_W +: TAG_W] != TAG_NONE);
    end

    cdb_arbiter_rr_pick #(
        .N_UF  (N_UF),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .elig  (elig),
        .last  (last_q),
        .grant (grant),
        .win   (win),
        .any   (any)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ack_q   <= '0;
            valid_q <= 1'b0;
            tag_q   <= TAG_NONE;
            data_q  <= DATA_NONE;
            last_q  <= PTR_W'(N_UF - 1);
        end else if (any && !bus.Flush) begin
            ack_q   <= grant;
            valid_q <= 1'b1;
            tag_q   <= bus.Req_tag[win*TAG_W +: TAG_W];
            data_q  <= bus.Req_data[win*DATA_W +: DATA_W];
            last_q  <= win;
        end else begin
            ack_q   <= '0;
            valid_q <= 1'b0;
            tag_q   <= TAG_NONE;
            data_q  <= DATA_NONE;
        end
    end

    assign bus.Ack         = ack_q;
    assign bus.CDB_valid   = valid_q;
    assign bus.Qi_CDB      = tag_q;
    assign bus.Qi_CDB_data = data_q;

`ifdef CDB_STATS_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Bcast_count    <= '0;
            Conflict_count <= '0;
        end else begin
            if (any && !bus.Flush && Bcast_count != CNT_MAX) begin
                Bcast_count <= Bcast_count + 1'b1;
            end
            if ($countones(elig) >= 2 && Conflict_count != CNT_MAX) begin
                Conflict_count <= Conflict_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized requesters,
// all checked every cycle against a rule-level model of the arbiter.
module tb_cdb_arbiter;

    localparam int N = 3;

    logic Clock;
    logic Reset;

    cdb_arbiter_if #(.N_UF(N)) bus ();

`ifdef CDB_STATS_EN
    logic [15:0] bcast_count;
    logic [15:0] conflict_count;
`endif

    cdb_arbiter #(.N_UF(N)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
`ifdef CDB_STATS_EN
        .Bcast_count    (bcast_count),
        .Conflict_count (conflict_count),
`endif
        .bus            (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: who was granted last, which Ack is currently showing, counters.
    int          m_last     = N - 1;
    logic [N-1:0] m_ack      = '0;
    logic [N-1:0] m_ack_prev = '0;
    logic [15:0] m_bc = '0;
    logic [15:0] m_cf = '0;

    function automatic logic [2:0] tag_of(int i);
        return bus.Req_tag[i*3 +: 3];
    endfunction

    function automatic logic [15:0] data_of(int i);
        return bus.Req_data[i*16 +: 16];
    endfunction

    task automatic set_uf(int i, logic req, logic [2:0] tag, logic [15:0] data);
        bus.Req[i]            = req;
        bus.Req_tag[i*3 +: 3] = tag;
        bus.Req_data[i*16 +: 16] = data;
    endtask

    // Predict the outcome of the coming edge from the rules, advance one clock, compare.
    task automatic cycle();
        logic [N-1:0] e_ack   = '0;
        logic [2:0]   e_tag   = 3'b000;
        logic [15:0]  e_data  = 16'hFFF0;
        logic         e_valid = 1'b0;
        int           winner  = -1;
        int           n_elig  = 0;
        for (int k = 1; k <= N; k++) begin
            int idx = (m_last + k) % N;
            if (bus.Req[idx] && !m_ack[idx] && tag_of(idx) != 3'b000) begin
                n_elig++;
                if (winner < 0) winner = idx;
            end
        end
        if (Reset) begin
            m_last = N - 1;
            m_bc   = '0;
            m_cf   = '0;
        end else begin
            if (n_elig >= 2 && m_cf != 16'hFFFF) m_cf = m_cf + 16'd1;
            if (winner >= 0 && !bus.Flush) begin
                e_ack[winner] = 1'b1;
                e_tag   = tag_of(winner);
                e_data  = data_of(winner);
                e_valid = 1'b1;
                m_last  = winner;
                if (m_bc != 16'hFFFF) m_bc = m_bc + 16'd1;
            end
        end
        m_ack_prev = m_ack;
        m_ack      = e_ack;
        @(posedge Clock);
        #1;
        n_checks++;
        if (bus.Ack !== e_ack) begin
            n_errors++;
            $display("FAIL ack t=%0t got %b want %b", $time, bus.Ack, e_ack);
        end
        n_checks++;
        if (bus.CDB_valid !== e_valid) begin
            n_errors++;
            $display("FAIL cdb_valid t=%0t got %b want %b", $time, bus.CDB_valid, e_valid);
        end
        n_checks++;
        if (bus.Qi_CDB !== e_tag) begin
            n_errors++;
            $display("FAIL qi_cdb t=%0t got %b want %b", $time, bus.Qi_CDB, e_tag);
        end
        n_checks++;
        if (bus.Qi_CDB_data !== e_data) begin
            n_errors++;
            $display("FAIL qi_cdb_data t=%0t got %h want %h", $time, bus.Qi_CDB_data, e_data);
        end
`ifdef CDB_STATS_EN
        n_checks++;
        if (bcast_count !== m_bc) begin
            n_errors++;
            $display("FAIL bcast_count t=%0t got %0d want %0d", $time, bcast_count, m_bc);
        end
        n_checks++;
        if (conflict_count !== m_cf) begin
            n_errors++;
            $display("FAIL conflict_count t=%0t got %0d want %0d", $time, conflict_count, m_cf);
        end
`endif
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) set_uf(i, 1'b0, 3'b000, 16'h0000);
        bus.Flush = 1'b0;
    endtask

    task automatic do_reset();
        clear_reqs();
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        set_uf(0, 1'b1, 3'b001, 16'h1000);
        set_uf(1, 1'b1, 3'b010, 16'h2000);
        set_uf(2, 1'b1, 3'b011, 16'h3000);
        bus.Flush = 1'b0;
        Reset = 1'b1;
        cycle();
        cycle();
        Reset = 1'b0;
        cycle();
        n_checks++;
        if (bus.Ack !== 3'b001 || bus.Qi_CDB !== 3'b001) begin
            n_errors++;
            $display("FAIL first_grant ack %b tag %b want ack 001 tag 001", bus.Ack, bus.Qi_CDB);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_uf(1, 1'b1, 3'b010, 16'h0042);
        cycle();
        n_checks++;
        if (bus.Qi_CDB_data !== 16'h0042 || bus.Ack !== 3'b010) begin
            n_errors++;
            $display("FAIL uf1_alone data %h ack %b want 0042 010", bus.Qi_CDB_data, bus.Ack);
        end
        cycle();
        set_uf(1, 1'b0, 3'b000, 16'h0000);
        cycle();
        n_checks++;
        if (bus.CDB_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL uf1_idle_after_drop valid %b want 0", bus.CDB_valid);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        set_uf(0, 1'b1, 3'b001, 16'h0A00);
        set_uf(1, 1'b1, 3'b010, 16'h0B00);
        set_uf(2, 1'b1, 3'b011, 16'h0C00);
        for (int n = 0; n < 9; n++) begin
            cycle();
            n_checks++;
            if (bus.Qi_CDB !== 3'((n % N) + 1)) begin
                n_errors++;
                $display("FAIL rotation n=%0d tag %b want %0d", n, bus.Qi_CDB, (n % N) + 1);
            end
            for (int i = 0; i < N; i++) begin
                if (m_ack_prev[i]) bus.Req_data[i*16 +: 16] = 16'($urandom);
            end
        end
    endtask

    task automatic test_slow();
        do_reset();
        set_uf(2, 1'b1, 3'b011, 16'h5555);
        for (int n = 0; n < 6; n++) begin
            cycle();
            n_checks++;
            if (bus.CDB_valid !== (n % 2 == 0)) begin
                n_errors++;
                $display("FAIL slow_uf2 n=%0d valid %b want %0d", n, bus.CDB_valid, n % 2 == 0);
            end
        end
        clear_reqs();
        cycle();
    endtask

    task automatic test_tag_none();
        do_reset();
        set_uf(0, 1'b1, 3'b000, 16'h1111);
        set_uf(1, 1'b1, 3'b101, 16'h2222);
        for (int n = 0; n < 6; n++) begin
            cycle();
            n_checks++;
            if (bus.Ack[0] !== 1'b0) begin
                n_errors++;
                $display("FAIL tag_none_uf0 n=%0d ack0 %b want 0", n, bus.Ack[0]);
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        set_uf(0, 1'b1, 3'b001, 16'h0101);
        set_uf(1, 1'b1, 3'b010, 16'h0202);
        bus.Flush = 1'b1;
        cycle();
        n_checks++;
        if (bus.CDB_valid !== 1'b0 || bus.Ack !== 3'b000) begin
            n_errors++;
            $display("FAIL flush_idle valid %b ack %b want 0 000", bus.CDB_valid, bus.Ack);
        end
        bus.Flush = 1'b0;
        cycle();
        n_checks++;
        if (bus.Ack !== 3'b001) begin
            n_errors++;
            $display("FAIL after_flush ack %b want 001", bus.Ack);
        end
        // Flush with Reset, then reset in mid-broadcast: both return to UF0 priority.
        cycle();
        bus.Flush = 1'b1;
        Reset = 1'b1;
        cycle();
        bus.Flush = 1'b0;
        Reset = 1'b0;
        cycle();
        n_checks++;
        if (bus.Ack !== 3'b001) begin
            n_errors++;
            $display("FAIL after_mid_reset ack %b want 001", bus.Ack);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            bus.Flush = ($urandom_range(0, 7) == 0);
            cycle();
            for (int i = 0; i < N; i++) begin
                if (m_ack_prev[i]) begin
                    if ($urandom_range(0, 1) == 1)
                        set_uf(i, 1'b1, 3'($urandom_range(1, 7)), 16'($urandom));
                    else
                        set_uf(i, 1'b0, 3'b000, 16'h0000);
                end else if (!bus.Req[i]) begin
                    if ($urandom_range(0, 2) == 0)
                        set_uf(i, 1'b1, 3'($urandom_range(0, 7)), 16'($urandom));
                end else if (tag_of(i) == 3'b000 && $urandom_range(0, 3) == 0) begin
                    set_uf(i, 1'b0, 3'b000, 16'h0000);
                end
            end
        end
        bus.Flush = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        clear_reqs();
        test_reset();
        test_single();
        test_rotation();
        test_slow();
        test_tag_none();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Arbiter and driver for the Common Data Bus (CDB) of the Tomasulo datapath.
- Functional units (UFs) raise broadcast requests carrying a result tag and data.
- The block grants at most one UF per cycle using round-robin priority.
- It registers the winner onto Qi_CDB / Qi_CDB_data, which the operand selectors and reservation stations snoop, and acknowledges the winner.

Parameters:
N_UF, 3, number of requesting functional units (2..8)
TAG_W, 3, reservation-station tag width
DATA_W, 16, result data width
TAG_NONE, 3'b000, tag value meaning "no producer"; also the idle CDB tag
DATA_NONE, 16'b1111_1111_1111_0000, idle CDB data value ("no value")

Ports:
Clock  input  1  single clock, rising edge
Reset  input  1  synchronous, active-high reset
Flush  input  1  synchronous squash: cancel any grant this cycle
Req  input  N_UF  per-UF broadcast request; held until Ack seen
Req_tag  input  N_UF*TAG_W  packed tags; UF i at [i*TAG_W +: TAG_W]
Req_data  input  N_UF*DATA_W  packed results; UF i at [i*DATA_W +: DATA_W]
Ack  output  N_UF  registered one-hot grant, high exactly one cycle
Qi_CDB  output  TAG_W  registered broadcast tag
Qi_CDB_data  output  DATA_W  registered broadcast data
CDB_valid  output  1  high when Qi_CDB / Qi_CDB_data carry a real broadcast

Behaviour:
- All state updates occur on posedge Clock.
- Reset (synchronous, active-high):
  - Ack=0, CDB_valid=0, Qi_CDB=TAG_NONE, Qi_CDB_data=DATA_NONE.
  - Round-robin pointer last = N_UF-1, so UF0 has first priority.
- Eligibility at each edge: elig[i] = Req[i] & ~Ack[i] & (Req_tag[i] != TAG_NONE).
  - The ~Ack term prevents a double grant while the requester is still seeing its Ack.
  - A request carrying TAG_NONE is never granted.
- Pick: first eligible i searching last+1, last+2, ... modulo N_UF.
- If a winner w exists and Flush=0, at the edge:
  - Ack <= one-hot(w), Qi_CDB <= Req_tag[w], Qi_CDB_data <= Req_data[w], CDB_valid <= 1, last <= w.
- Otherwise (no eligible request, or Flush=1):
  - Ack <= 0, CDB_valid <= 0, Qi_CDB <= TAG_NONE, Qi_CDB_data <= DATA_NONE.
  - last is unchanged.
- Latency: Req sampled at edge k, broadcast and Ack visible during cycle k..k+1. There is one cycle of latency and each broadcast lasts exactly one cycle.
- Requester protocol:
  - Hold Req, tag and data stable until Ack=1 is sampled.
  - At that same edge, drop Req or present the next result.
  - Back-to-back grants to one UF are possible only when it is the sole eligible requester. Minimum spacing is then 2 cycles because of the ~Ack mask.
- Fairness: with all N_UF continuously eligible, grants rotate strictly 0,1,...,N_UF-1. The worst-case wait is N_UF grant cycles.
- Flush together with Reset: Reset dominates. Flush has no effect on the pointer.
- Reset mid-broadcast: outputs go idle at the next edge. Pending requests are re-arbitrated from UF0 afterwards.

Optional Feature:
CDB_STATS_EN
- Defined: adds outputs Bcast_count[15:0] and Conflict_count[15:0], both cleared by Reset.
  - Bcast_count increments on every edge that sets CDB_valid.
  - Conflict_count increments on every edge where two or more UFs are eligible.
  - Both counters saturate at 16'hFFFF (no wrap).
  - Flush does not increment Bcast_count.
- Undefined: the ports and counters do not exist; the remaining behaviour is identical.

Decomposition:
- Shared include/package tomasulo_defs: TAG_W, DATA_W, TAG_NONE, DATA_NONE (shared with the operand selector and reservation stations).
- One combinational sub-module rr_pick:
  - Inputs: elig[N_UF], last pointer.
  - Outputs: one-hot grant, winner index, any flag.
  - Instantiated once.
- cdb_arbiter holds the registers, masking and muxing.

Test Plan:
- Reset asserted 2 cycles with Req=3'b111 -> Ack=0, CDB_valid=0, Qi_CDB=3'b000, Qi_CDB_data=16'hFFF0 throughout and one cycle after release; then first grant goes to UF0.
- UF1 alone: Req=3'b010, tag 3'b010, data 16'h0042 -> next cycle Qi_CDB=3'b010, Qi_CDB_data=16'h0042, CDB_valid=1, Ack=3'b010. Req dropped on the Ack edge -> bus idle the following cycle.
- Req=3'b111 held continuously, each UF re-requesting right after its Ack, tags 001/010/011 -> broadcast tags 001,010,011,001,... on consecutive cycles; each Ack is one-hot and lasts one cycle.
- Slow requester: UF2 keeps Req high for 3 cycles after its Ack -> UF2 is granted only on alternate cycles, never in the cycle following its Ack.
- UF0 requests with tag 3'b000 while UF1 requests with 3'b101 -> only UF1 is ever granted; UF0 is never acked.
- Flush=1 on an edge with Req=3'b011 -> next cycle bus idle and Ack=0. Flush=0 next edge -> grant to the UF that would have won (pointer unchanged).
